// File: rtl/rega_pkg.sv
// rtl/rega_pkg.sv - state codes and default timing for the irrigation sequencer
package rega_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ASP   = 3'd1,
    GOT   = 3'd2,
    PAUSA = 3'd3,
    ERRO  = 3'd4
  } estado_t;

  localparam int TICK_DIV_DEF = 50_000_000;
  localparam int T_ASP_DEF    = 30;
  localparam int T_GOT_DEF    = 120;
  localparam int T_PAUSA_DEF  = 10;

endpackage

// File: rtl/rega_sequenciador_if.sv
// rtl/rega_sequenciador_if.sv - sensor inputs and actuator outputs of the sequencer
interface rega_sequenciador_if;

  logic       H, M, L;
  logic       Us, Ua, T;
  logic       Bs, Vs, Ve, Al;
  logic [2:0] estado;

  modport master (
    output H, M, L, Us, Ua, T,
    input  Bs, Vs, Ve, Al, estado
  );

  modport slave (
    input  H, M, L, Us, Ua, T,
    output Bs, Vs, Ve, Al, estado
  );

endinterface

// File: rtl/rega_tick.sv
// rtl/rega_tick.sv - free-running prescaler, one-cycle tick every TICK_DIV clocks
module rega_tick #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic Rst,
  output logic tick
);

  localparam int            W    = $clog2(TICK_DIV);
  localparam logic [W-1:0]  LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge Rst) begin
    if (!Rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  // Tick is consumed on the TICK_DIV-th edge after reset release.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/rega_sequenciador.sv
// rtl/rega_sequenciador.sv - irrigation FSM: sprinkler/drip runs, lockout, sensor fault, tank inlet
module rega_sequenciador
  import rega_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int T_ASP    = T_ASP_DEF,
  parameter int T_GOT    = T_GOT_DEF,
  parameter int T_PAUSA  = T_PAUSA_DEF
) (
  input  logic            clock,
  input  logic            Rst,
  rega_sequenciador_if.slave io
);

  localparam logic [7:0] LD_ASP   = 8'(T_ASP);
  localparam logic [7:0] LD_GOT   = 8'(T_GOT);
  localparam logic [7:0] LD_PAUSA = 8'(T_PAUSA);

  logic       tick;
  logic [5:0] sync1, sync2;
  logic       h, m, l, us, ua, t;
  logic       err, sprinkler, need;

  estado_t    state;
  logic [7:0] timer;
  logic       started;
  logic       err_ok;
  logic       bs_q, vs_q, ve_q, al_q;
  logic [2:0] estado_q;

  rega_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .Rst   (Rst),
    .tick  (tick)
  );

  always_ff @(posedge clock or negedge Rst) begin
    if (!Rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {io.H, io.M, io.L, io.Us, io.Ua, io.T};
      sync2 <= sync1;
    end
  end

  assign {h, m, l, us, ua, t} = sync2;
  assign err       = (h & ~m) | (m & ~l);
  assign sprinkler = ~ua & ~t;
  assign need      = ~us;

  always_ff @(posedge clock or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      timer    <= '0;
      started  <= 1'b0;
      err_ok   <= 1'b0;
      bs_q     <= 1'b0;
      vs_q     <= 1'b0;
      ve_q     <= 1'b0;
      al_q     <= 1'b0;
      estado_q <= '0;
    end else begin
      if (tick) started <= 1'b1;

      bs_q     <= (state == ASP);
      vs_q     <= (state == GOT);
      al_q     <= (state == ERRO) | ~l;
      estado_q <= state;

      if (state == ERRO)  ve_q <= 1'b0;
      else if (!m)        ve_q <= 1'b1;
      else if (h)         ve_q <= 1'b0;

      if (err) begin
        state  <= ERRO;
        err_ok <= 1'b0;
      end else begin
        if (tick && timer != 8'd0) timer <= timer - 8'd1;
        case (state)
          // No run may start before the first tick after reset release.
          IDLE: if (need && (started || tick)) begin
            if (sprinkler && m) begin
              state <= ASP;
              timer <= LD_ASP;
            end else if (!sprinkler && l) begin
              state <= GOT;
              timer <= LD_GOT;
            end
          end
          ASP: if (timer == 8'd0 || !m || us) begin
            state <= PAUSA;
            timer <= LD_PAUSA;
          end
          GOT: if (timer == 8'd0 || !l || us) begin
            state <= PAUSA;
            timer <= LD_PAUSA;
          end
          PAUSA: if (timer == 8'd0) state <= IDLE;
          // err_ok remembers one clean tick; the second consecutive one releases.
          ERRO: if (tick) begin
            if (err_ok) begin
              state <= PAUSA;
              timer <= LD_PAUSA;
            end else begin
              err_ok <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign io.Bs     = bs_q;
  assign io.Vs     = vs_q;
  assign io.Ve     = ve_q;
  assign io.Al     = al_q;
  assign io.estado = estado_q;

endmodule

// File: tb/tb_rega_sequenciador.sv
// tb/tb_rega_sequenciador.sv - directed self-checking bench for rega_sequenciador
module tb_rega_sequenciador;

  logic clock = 1'b0;
  logic Rst   = 1'b0;
  int   edges;
  int   n_checks = 0;
  int   n_err    = 0;

  rega_sequenciador_if io();

  rega_sequenciador #(
    .TICK_DIV (4),
    .T_ASP    (5),
    .T_GOT    (8),
    .T_PAUSA  (3)
  ) dut (
    .clock (clock),
    .Rst   (Rst),
    .io    (io.slave)
  );

  always #5 clock = ~clock;

  // edges = number of rising edges since the last reset release
  always @(posedge clock or negedge Rst) begin
    if (!Rst) edges <= 0;
    else      edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_in(input logic h, m, l, us, ua, t);
    io.H = h; io.M = m; io.L = l; io.Us = us; io.Ua = ua; io.T = t;
  endtask

  task automatic at(input int k);
    while (edges < k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    Rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Sprinkler run and automatic restart
    set_in(1, 1, 1, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_bs", io.Bs, 0);
    check("rst_vs", io.Vs, 0);
    check("rst_ve", io.Ve, 0);
    check("rst_al", io.Al, 0);
    check("rst_estado", io.estado, 0);
    @(negedge clock);
    Rst = 1'b1;
    at(4);  check("asp_wait_tick", io.Bs, 0);
    at(5);  check("asp_bs_on", io.Bs, 1);
            check("asp_estado", io.estado, 1);
            check("asp_al", io.Al, 0);
            check("asp_ve", io.Ve, 0);
    at(25); check("asp_last", io.Bs, 1);
    at(26); check("asp_off", io.Bs, 0);
            check("pausa_estado", io.estado, 3);
    at(37); check("pausa_last", io.estado, 3);
    at(38); check("idle_estado", io.estado, 0);
            check("idle_bs", io.Bs, 0);
    at(39); check("asp2_bs", io.Bs, 1);
            check("asp2_estado", io.estado, 1);

    // Reset mid-run drops Bs without a clock edge
    #2;
    Rst = 1'b0;
    #1;
    check("arst_bs", io.Bs, 0);
    check("arst_estado", io.estado, 0);
    @(negedge clock);
    Rst = 1'b1;
    at(3);  check("post_rst_estado", io.estado, 0);
    at(4);  check("post_rst_no_run", io.Bs, 0);
    at(5);  check("post_rst_run", io.Bs, 1);

    // Drip run, mode change ignored, early stop on wet soil
    set_in(1, 1, 1, 0, 1, 0);
    do_reset();
    at(5);  check("got_vs_on", io.Vs, 1);
            check("got_estado", io.estado, 2);
    at(9);  io.Ua = 1'b0;
    at(12); check("got_mode_vs", io.Vs, 1);
            check("got_mode_bs", io.Bs, 0);
    io.Us = 1'b1;
    at(15); check("got_us_last", io.Vs, 1);
    at(16); check("got_us_off", io.Vs, 0);
            check("got_us_estado", io.estado, 3);

    // Level loss during sprinkler run, inlet hysteresis
    set_in(1, 1, 1, 0, 0, 0);
    do_reset();
    at(5);  check("lvl_bs_on", io.Bs, 1);
    at(10); io.H = 1'b0; io.M = 1'b0;
    at(13); check("lvl_bs_last", io.Bs, 1);
            check("lvl_ve_set", io.Ve, 1);
    at(14); check("lvl_bs_off", io.Bs, 0);
            check("lvl_estado", io.estado, 3);
    at(20); io.M = 1'b1;
    at(26); check("lvl_ve_hold", io.Ve, 1);
    io.H = 1'b1;
    at(28); check("lvl_ve_before_h", io.Ve, 1);
    at(29); check("lvl_ve_clr", io.Ve, 0);

    // Sensor fault during drip run, recovery after two clean ticks
    set_in(0, 1, 1, 0, 1, 0);
    do_reset();
    at(5);  check("err_vs_on", io.Vs, 1);
    at(6);  io.H = 1'b1; io.M = 1'b0;
    at(9);  check("err_vs_last", io.Vs, 1);
    at(10); check("err_estado", io.estado, 4);
            check("err_vs", io.Vs, 0);
            check("err_ve", io.Ve, 0);
            check("err_al", io.Al, 1);
    at(14); io.H = 1'b0; io.M = 1'b1;
    at(24); check("err_hold", io.estado, 4);
    at(25); check("err_to_pausa", io.estado, 3);
            check("err_al_clr", io.Al, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
